ascii_to_decimal: RTL



---
 rtl/ascii_to_decimal.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ascii_to_decimal.sv
// Byte-serial ASCII-to-binary converter. Responder on a four-phase byte
// handshake (rxData/rxDataValid in, rxDone back). Decimal digits accumulate
// into an unsigned WIDTH-bit value. A CR, LF or NUL terminator publishes the
// value on decimal and raises complete, with error flagging a malformed or
// overflowing number.
module ascii_to_decimal #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rxData,
    input  logic             rxDataValid,
    output logic             rxDone,
    output logic [WIDTH-1:0] decimal,
    output logic             complete,
    output logic             error
);

    typedef enum logic [1:0] {StWait, StEval, StAck} state_e;

    state_e             state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               seen_q, seen_d;   // at least one digit in the current number
    logic               ovf_q, ovf_d;
    logic               bad_q, bad_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   dec_q, dec_d;
    logic               cmp_q, cmp_d;
    logic               err_q, err_d;
    // Staged results: computed in EVAL, published together with rxDone one edge later.
    logic [WIDTH-1:0]   sdec_q, sdec_d;
    logic               scmp_q, scmp_d;
    logic               serr_q, serr_d;

    logic               is_digit, is_space, is_term;
    logic [WIDTH-1:0]   acc_base;
    logic [WIDTH+3:0]   acc_ext, prod;

    assign is_digit = (byte_q >= 8'h30) && (byte_q <= 8'h39);
    assign is_space = (byte_q == 8'h20);
    assign is_term  = (byte_q == 8'h0D) || (byte_q == 8'h0A) || (byte_q == 8'h00);

    // acc*10 + d with four guard bits so any overflow shows up above bit WIDTH-1.
    assign acc_base = seen_q ? acc_q : '0;
    assign acc_ext  = {4'b0000, acc_base};
    assign prod     = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, byte_q[3:0]};

    assign rxDone   = done_q;
    assign decimal  = dec_q;
    assign complete = cmp_q;
    assign error    = err_q;

    // Next-state: handshake sequencing, character classification and accumulation.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;
        bad_d   = bad_q;
        done_d  = done_q;
        dec_d   = dec_q;
        cmp_d   = cmp_q;
        err_d   = err_q;
        sdec_d  = sdec_q;
        scmp_d  = scmp_q;
        serr_d  = serr_q;

        unique case (state_q)
            StWait: begin
                if (rxDataValid) begin
                    byte_d  = rxData;
                    state_d = StEval;
                end
            end
            StEval: begin
                state_d = StAck;
                if (is_digit) begin
                    if (!seen_q) begin
                        scmp_d = 1'b0;
                        serr_d = 1'b0;
                    end
                    acc_d  = prod[WIDTH-1:0];
                    seen_d = 1'b1;
                    if (|prod[WIDTH+3:WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                end else if (is_space && !seen_q) begin
                    // Leading space: nothing changes.
                end else if (is_term) begin
                    if (seen_q && !ovf_q && !bad_q) begin
                        sdec_d = acc_q;
                        serr_d = 1'b0;
                    end else begin
                        sdec_d = '0;
                        serr_d = 1'b1;
                    end
                    scmp_d = 1'b1;
                    acc_d  = '0;
                    seen_d = 1'b0;
                    ovf_d  = 1'b0;
                    bad_d  = 1'b0;
                end else begin
                    bad_d = 1'b1;
                end
            end
            StAck: begin
                if (!done_q) begin
                    done_d = 1'b1;
                    dec_d  = sdec_q;
                    cmp_d  = scmp_q;
                    err_d  = serr_q;
                end else if (!rxDataValid) begin
                    done_d  = 1'b0;
                    state_d = StWait;
                end
            end
            default: state_d = StWait;
        endcase
    end

    // State and output registers; reset discards any partial number at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            byte_q  <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            dec_q   <= '0;
            cmp_q   <= 1'b0;
            err_q   <= 1'b0;
            sdec_q  <= '0;
            scmp_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            dec_q   <= dec_d;
            cmp_q   <= cmp_d;
            err_q   <= err_d;
            sdec_q  <= sdec_d;
            scmp_q  <= scmp_d;
            serr_q  <= serr_d;
        end
    end

endmodule
